// File: rtl/breadboard_sweeper.sv
// breadboard_sweeper
//   Clocked stimulus-and-capture stage for the 4-input / 10-output breadboard
//   block. A start request walks {w,x,y,z} through rows 0..15 (w = MSB). For
//   each row it waits SETTLE_CYCLES clocks, captures f, and offers the captured
//   row downstream on a valid/ready handshake.
//
//   Optional build macro: BREADBOARD_SWEEPER_CHECKSUM_EN
//     defined   -> checksum is a 16-bit wrapping sum of every accepted row_data,
//                  cleared on rst and on start
//     undefined -> checksum is tied to 0 and no accumulator is built
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a sweep (only looked at in IDLE)
//   f          in   breadboard outputs, bit 0 = f0
//   w,x,y,z    out  breadboard inputs, row index bits 3..0
//   row_valid  out  captured row presented
//   row_ready  in   downstream accepts the row
//   row_idx    out  row number of row_data
//   row_data   out  captured f
//   busy       out  sweep in progress
//   done       out  one-cycle pulse after the last row is accepted
//   checksum   out  running sum of accepted rows (see macro above)
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for start, wxyz holds its last value
// DRIVE   | wxyz applied, settle counter running
// PRESENT | captured row offered, waiting for row_ready
// FINISH  | single cycle, done pulse, back to IDLE

module breadboard_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned OUT_W         = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] f,
  output logic             w,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [3:0]       row_idx,
  output logic [OUT_W-1:0] row_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_PRESENT,
    S_FINISH
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             row_valid_q, row_valid_d;
  logic [3:0]       row_idx_q, row_idx_d;
  logic [OUT_W-1:0] row_data_q, row_data_d;

  logic handshake;
  logic start_accept;

  assign handshake    = row_valid_q & row_ready;
  assign start_accept = (state_q == S_IDLE) & start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      row_valid_q <= 1'b0;
      row_idx_q   <= '0;
      row_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      row_data_q  <= row_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    row_valid_d = row_valid_q;
    row_idx_d   = row_idx_q;
    row_data_d  = row_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // f is captured on the edge where the counter is already zero, i.e.
        // the SETTLE_CYCLES-th edge after wxyz changed.
        if (cnt_q == 8'd0) begin
          row_data_d  = f;
          row_idx_d   = idx_q;
          row_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PRESENT: begin
        if (handshake) begin
          row_valid_d = 1'b0;
          if (idx_q == 4'd15) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            cnt_d   = CNT_LOAD;
            state_d = S_DRIVE;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // wxyz is the live row index register, so it only moves on start or handshake.
  assign {w, x, y, z} = idx_q;
  assign row_valid    = row_valid_q;
  assign row_idx      = row_idx_q;
  assign row_data     = row_data_q;
  assign busy         = (state_q == S_DRIVE) || (state_q == S_PRESENT);
  assign done         = (state_q == S_FINISH);

`ifdef BREADBOARD_SWEEPER_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) begin
      checksum_d = '0;
    end else if (handshake) begin
      checksum_d = checksum_q + 16'(row_data_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign checksum            = 16'h0000;
`endif

endmodule
